// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer: one shared 2W-bit shift/accumulate datapath,
// fixed latency (W BUSY cycles + one FIX cycle), result returned over valid/ready.
module muldiv_seq #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         start_valid,
   output logic         start_ready,
   input  logic [4:0]   op,
   input  logic [W-1:0] src_a,
   input  logic [W-1:0] src_b,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] result,
   output logic         busy,
   output logic [1:0]   dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
   // start_ready is combinational from state and flush; res_valid is a pure state decode.

   localparam int CW = $clog2(W);
   localparam logic [4:0] OP_MUL   = 5'd10;
   localparam logic [4:0] OP_MULH  = 5'd11;
   localparam logic [4:0] OP_MULHU = 5'd12;
   localparam logic [4:0] OP_DIV   = 5'd13;
   localparam logic [4:0] OP_MOD   = 5'd14;
   localparam logic [4:0] OP_DIVU  = 5'd15;
   localparam logic [4:0] OP_MODU  = 5'd16;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [4:0]      op_q, op_d;
   logic [2*W-1:0]  acc_q, acc_d;
   logic [W-1:0]    opnd_q, opnd_d;
   logic            sgn_q, sgn_d;
   logic            sgn_a_q, sgn_a_d;
   logic            b_zero_q, b_zero_d;
   logic [W-1:0]    result_q, result_d;

   logic            in_signed, in_mul;
   logic [W-1:0]    a_mag, b_mag;
   logic [W:0]      mul_sum;
   logic [W:0]      div_rem, div_sub;
   logic            div_ge, cur_mul;
   logic [2*W-1:0]  prod;
   logic [W-1:0]    quo, rem;

   always_comb begin
      in_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_MOD);
      in_mul    = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHU);
      a_mag     = (in_signed && src_a[W-1]) ? (~src_a + 1'b1) : src_a;
      b_mag     = (in_signed && src_b[W-1]) ? (~src_b + 1'b1) : src_b;
      cur_mul   = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_MULHU);

      // Multiply: acc = {partial high, remaining multiplier bits}, shifted right each step.
      mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      // Divide: acc = {remainder, dividend bits shifting out / quotient bits shifting in}.
      div_rem = acc_q[2*W-1:W-1];
      div_ge  = div_rem >= {1'b0, opnd_q};
      div_sub = div_rem - {1'b0, opnd_q};

      prod = sgn_q ? (~acc_q + 1'b1) : acc_q;
      // With a zero divisor the restoring loop leaves |a| in the remainder, so the
      // normal sign fix-up already reproduces src_a; only the quotient needs forcing.
      quo  = b_zero_q ? '1 : (sgn_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0]);
      rem  = sgn_a_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      sgn_d    = sgn_q;
      sgn_a_d  = sgn_a_q;
      b_zero_d = b_zero_q;
      result_d = result_q;

      case (state_q)
         S_IDLE: begin
            if (start_valid && start_ready) begin
               state_d  = S_BUSY;
               cnt_d    = '0;
               op_d     = op;
               opnd_d   = in_mul ? a_mag : b_mag;
               acc_d    = {{W{1'b0}}, (in_mul ? b_mag : a_mag)};
               sgn_d    = in_signed && (src_a[W-1] ^ src_b[W-1]);
               sgn_a_d  = in_signed && src_a[W-1];
               b_zero_d = (src_b == '0);
            end
         end
         S_BUSY: begin
            if (cur_mul) acc_d = {mul_sum, acc_q[W-1:1]};
            else if (div_ge) acc_d = {div_sub[W-1:0], acc_q[W-2:0], 1'b1};
            else acc_d = {div_rem[W-1:0], acc_q[W-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) state_d = S_FIX;
         end
         S_FIX: begin
            state_d = S_DONE;
            case (op_q)
               OP_MUL:            result_d = prod[W-1:0];
               OP_MULH, OP_MULHU: result_d = prod[2*W-1:W];
               OP_DIV, OP_DIVU:   result_d = quo;
               OP_MOD, OP_MODU:   result_d = rem;
               default:           result_d = '0;
            endcase
         end
         S_DONE: begin
            if (res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (flush) state_d = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         sgn_q    <= 1'b0;
         sgn_a_q  <= 1'b0;
         b_zero_q <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         sgn_q    <= sgn_d;
         sgn_a_q  <= sgn_a_d;
         b_zero_q <= b_zero_d;
         result_q <= result_d;
      end
   end

   assign start_ready = (state_q == S_IDLE) && !flush;
   assign res_valid   = (state_q == S_DONE);
   assign busy        = (state_q != S_IDLE);
   assign result      = result_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed vectors, latency, backpressure,
// flush and asynchronous reset behaviour.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        start_valid;
   logic        start_ready;
   logic [4:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] result;
   logic        busy;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;

   muldiv_seq #(.W(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .op          (op),
      .src_a       (src_a),
      .src_b       (src_b),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .result      (result),
      .busy        (busy),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Present a request at the falling edge; it is accepted on the next rising edge.
   task automatic start_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op = o; src_a = a; src_b = b; start_valid = 1'b1;
      @(posedge clk);
      #1 start_valid = 1'b0;
   endtask

   // Count edges after acceptance until res_valid, bounded.
   task automatic wait_result(input string tag, input logic [31:0] exp);
      int n;
      n = 0;
      while (!res_valid && n < 40) begin
         @(posedge clk);
         #1 n++;
      end
      check({tag, "_lat"}, n, 33);
      check({tag, "_res"}, result, exp);
   endtask

   task automatic take_result(input string tag);
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      check({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
      @(negedge clk);
      check({tag, "_sready_after"}, {31'b0, start_ready}, 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      start_op(o, a, b);
      wait_result(tag, exp);
      take_result(tag);
   endtask

   initial begin
      logic [31:0] held;
      logic        saw_valid, saw_busy;

      rst_n = 1'b0; flush = 1'b0; start_valid = 1'b0; op = '0;
      src_a = '0; src_b = '0; res_ready = 1'b0;
      #12;
      check("rst_result",    result, 32'd0);
      check("rst_res_valid", {31'b0, res_valid}, 32'd0);
      check("rst_busy",      {31'b0, busy}, 32'd0);
      check("rst_sready",    {31'b0, start_ready}, 32'd1);
      check("rst_state",     {30'b0, dbg_state}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("mul",    5'd10, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB);
      run_op("mulh",   5'd11, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF);
      run_op("mulhu",  5'd12, 32'hFFFFFFFD, 32'd7, 32'h00000006);
      run_op("div",    5'd13, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
      run_op("mod",    5'd14, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
      run_op("divu",   5'd15, 32'd7, 32'd2, 32'd3);
      run_op("modu",   5'd16, 32'd7, 32'd2, 32'd1);
      run_op("divu0",  5'd15, 32'h1234, 32'd0, 32'hFFFFFFFF);
      run_op("modu0",  5'd16, 32'h1234, 32'd0, 32'h00001234);
      run_op("div0s",  5'd13, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF);
      run_op("mod0s",  5'd14, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9);
      run_op("divovf", 5'd13, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
      run_op("modovf", 5'd14, 32'h80000000, 32'hFFFFFFFF, 32'd0);
      run_op("div_m",  5'd13, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2);
      run_op("mod_m",  5'd14, 32'd100, 32'hFFFFFFF9, 32'd2);
      run_op("mul_big",5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
      run_op("badop",  5'd3, 32'd5, 32'd6, 32'd0);

      // Backpressure: result and busy hold while res_ready stays low.
      start_op(5'd10, 32'd1000, 32'd1000);
      wait_result("bp", 32'd1000000);
      held = result;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_hold", result, held);
         check("bp_busy", {31'b0, busy & res_valid}, 32'd1);
      end
      take_result("bp");

      // Flush mid-BUSY with a competing request.
      start_op(5'd15, 32'd50, 32'd3);
      repeat (11) @(posedge clk);
      @(negedge clk);
      flush = 1'b1; start_valid = 1'b1; op = 5'd10; src_a = 32'd2; src_b = 32'd2;
      #1 check("fl_sready", {31'b0, start_ready}, 32'd0);
      @(posedge clk);
      #1 flush = 1'b0; start_valid = 1'b0;
      check("fl_busy", {31'b0, busy}, 32'd0);
      check("fl_state", {30'b0, dbg_state}, 32'd0);
      saw_valid = 1'b0; saw_busy = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         saw_valid = saw_valid | res_valid;
         saw_busy  = saw_busy | busy;
      end
      check("fl_no_valid", {31'b0, saw_valid}, 32'd0);
      check("fl_no_accept", {31'b0, saw_busy}, 32'd0);

      // Asynchronous reset mid-BUSY.
      start_op(5'd10, 32'd9, 32'd9);
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("ar_busy", {31'b0, busy}, 32'd0);
      check("ar_valid", {31'b0, res_valid}, 32'd0);
      check("ar_result", result, 32'd0);
      check("ar_sready", {31'b0, start_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("ar_mul", 5'd10, 32'd5, 32'd6, 32'd30);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the execute stage. It takes the long-latency ALU operations (ALU_MUL, ALU_MULH, ALU_MULHU, ALU_DIV, ALU_MOD, ALU_DIVU, ALU_MODU) off the single-cycle ALU. It runs them on one shared 64-bit shift/accumulate datapath with a fixed latency. Results are returned over a valid/ready handshake, and busy stalls issue.

## Interface
- `W`, default 32: operand/result width. The counter is $clog2(W) bits.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `flush` in 1: synchronous kill of any in-flight operation.
- `start_valid` in 1: request carries a new operation.
- `start_ready` out 1: sequencer can accept a request.
- `op` in 5: AluCtrl encoding. 10=MUL, 11=MULH, 12=MULHU, 13=DIV, 14=MOD, 15=DIVU, 16=MODU.
- `src_a` in W: rj value (multiplicand / dividend).
- `src_b` in W: rk value (multiplier / divisor).
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer takes the result.
- `result` out W: final value.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, BUSY, FIX, DONE.
- IDLE -> BUSY on start_valid && start_ready. On that edge, latch op and the operand magnitudes, and clear the counter.
  - Signed ops (MUL, MULH, DIV, MOD) latch abs values.
  - The sign flags latched are: product sign = a[W-1]^b[W-1]; quotient sign = a[W-1]^b[W-1]; remainder sign = a[W-1].
- BUSY: one bit per cycle, W cycles. The counter runs 0..W-1, then BUSY -> FIX.
  - Multiply: unsigned shift-add into the 64-bit accumulator.
  - Divide: restoring. Shift the remainder left with the next dividend bit. If rem >= divisor, subtract and set the quotient bit.
- FIX -> DONE, one cycle. Apply the sign correction (two's complement negate when the sign flag is set) and select the result:
  - MUL: low W bits.
  - MULH/MULHU: high W bits.
  - DIV/DIVU: quotient.
  - MOD/MODU: remainder.
- Special cases, resolved in FIX at the same latency:
  - Divide by zero: quotient = all ones; remainder = src_a unchanged.
  - Signed overflow (a = 0x80000000, b = 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
  - Signed division truncates toward zero. A nonzero remainder takes the sign of the dividend.
- DONE -> IDLE on res_valid && res_ready. result holds its value until the next FIX.
- An op code outside 10..16 is still accepted and completes with result = 0.
- flush: the next edge forces IDLE from any state, drops res_valid, and discards any pending result. flush beats start_valid and res_ready in the same cycle.

## Timing
- Reset values: state IDLE, result 0, res_valid 0, busy 0, counter 0. start_ready reads 1 during and after reset unless flush is high.
- start_ready = (state==IDLE) && !flush, combinational. Requests are not accepted in DONE; there is no back-to-back overlap.
- Latency: acceptance edge E0. BUSY covers edges E1..E32 and FIX is entered after E32. E33 enters DONE. res_valid is high from cycle 33 after acceptance, independent of op and operand values.
- res_valid stays high and result stays stable while res_ready is low, for an unbounded time.
- The handshake completes on the edge where res_valid && res_ready. busy falls on that same edge, and start_ready is high in the following cycle.
- Reset asserted mid-operation: all state returns immediately (asynchronously) to the reset values. No partial result is ever presented.
- All arithmetic is modulo 2^W except the 64-bit product accumulator. Negation of 0x80000000 yields 0x80000000.

## Test plan
- MUL a=0xFFFFFFFD (-3), b=7 -> after 33 cycles result=0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
- DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD; MOD same -> 0xFFFFFFFF; DIVU a=7, b=2 -> 3; MODU -> 1.
- Divide by zero: DIVU a=0x1234, b=0 -> 0xFFFFFFFF; MODU -> 0x1234. Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; MOD -> 0.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid -> result stable and busy=1 throughout. Raise res_ready -> IDLE next edge, and start_ready=1 in the following cycle.
- Flush mid-BUSY (cycle 12) with start_valid also high -> IDLE next edge, res_valid never asserts, and the new request is not accepted in the flush cycle.
- Assert rst_n=0 mid-BUSY -> outputs immediately go to reset values. After release, a new MUL 5x6 returns 30 at exactly 33 cycles.
